mem_arbiter: RTL and testbench

//  Sequences the single shared RAM port between instruction fetch and data load/store.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single shared RAM port between instruction fetch and
// data load/store. Data has fixed priority over fetch; there is no preemption, and
// an access that waits too long for ram_ready is ended with an error word and a
// sticky err flag.
//
// Optional feature macro: MEM_ARB_PERF_EN adds perf_istall/perf_dstall counters.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no access in flight; picks data first, then fetch
// IACC  | fetch access on RAM, waiting for ram_ready / timeout / drop
// DACC  | data access on RAM, waiting for ram_ready / timeout / drop
// DONE  | one-cycle completion: served requester sees its wait low
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_istall,
  output logic [31:0]       perf_dstall
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] BAD_WORD = DATA_W'(32'hBAD1BAD1);

  typedef enum logic [1:0] {S_IDLE, S_IACC, S_DACC, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic              r_is_write;
  logic              r_served_d;
  logic              r_err;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic              w_dreq;
  logic              w_start_i;
  logic              w_start_d;
  logic              w_finish;
  logic              w_timeout;
  logic [DATA_W-1:0] w_word;

  assign w_dreq    = dREN | dWEN;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_word    = w_timeout ? BAD_WORD : ram_load;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state selection; a dropped request aborts before ready/timeout are considered
  always_comb begin
    w_state_nxt = r_state;
    w_start_i   = 1'b0;
    w_start_d   = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dreq) begin
          w_state_nxt = S_DACC;
          w_start_d   = 1'b1;
        end else if (iREN) begin
          w_state_nxt = S_IACC;
          w_start_i   = 1'b1;
        end
      end
      S_IACC, S_DACC: begin
        if ((r_state == S_IACC) ? !iREN : !w_dreq) begin
          w_state_nxt = S_IDLE;
        end else if (ram_ready) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
        end else if (w_cnt_inc == TO_VAL) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access latches, timeout counter, returned words and sticky error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_store    <= '0;
      r_is_write <= 1'b0;
      r_served_d <= 1'b0;
      r_err      <= 1'b0;
      r_iload    <= '0;
      r_dload    <= '0;
    end else begin
      if (w_start_i) begin
        r_addr     <= iaddr;
        r_is_write <= 1'b0;
        r_served_d <= 1'b0;
      end
      if (w_start_d) begin
        r_addr     <= daddr;
        r_store    <= dstore;
        r_is_write <= dWEN;
        r_served_d <= 1'b1;
      end
      if (r_state == S_IACC || r_state == S_DACC) r_cnt <= w_cnt_inc;
      else                                        r_cnt <= '0;
      if (w_finish) begin
        if (r_served_d) r_dload <= w_word;
        else            r_iload <= w_word;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign ram_ren   = (r_state == S_IACC) | ((r_state == S_DACC) & ~r_is_write);
  assign ram_wen   = (r_state == S_DACC) & r_is_write;
  assign ram_addr  = r_addr;
  assign ram_store = r_store;
  assign iwait     = iREN & ~((r_state == S_DONE) & ~r_served_d);
  assign dwait     = w_dreq & ~((r_state == S_DONE) & r_served_d);
  assign iload     = r_iload;
  assign dload     = r_dload;
  assign err       = r_err;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_istall;
  logic [31:0] r_perf_dstall;

  // Saturating stall-cycle counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_perf_istall <= '0;
      r_perf_dstall <= '0;
    end else begin
      if (iwait && r_perf_istall != 32'hFFFFFFFF) r_perf_istall <= r_perf_istall + 32'd1;
      if (dwait && r_perf_dstall != 32'hFFFFFFFF) r_perf_dstall <= r_perf_dstall + 32'd1;
    end
  end

  assign perf_istall = r_perf_istall;
  assign perf_dstall = r_perf_dstall;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: requester drivers push expected results into queues,
// a RAM model returns address-derived data with random latency, and a monitor
// pops and compares whenever a requester sees its wait signal drop.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_store;
  logic [DW-1:0] ram_load = '0;
  logic          ram_ready = 1'b0;
  logic          err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_istall;
  logic [31:0]   perf_dstall;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .err(err)
`ifdef MEM_ARB_PERF_EN
    , .perf_istall(perf_istall), .perf_dstall(perf_dstall)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] iq[$];
  logic [32:0] dq[$];   // bit 32: dload must be checked (reads only)
  logic [63:0] wq[$];   // {addr, data} of expected RAM writes
  int i_done_cyc = 0, d_done_cyc = 0, i_done_n = 0, d_done_n = 0;
  int force_lat = -1;
  int strobe_cnt = 0;

  // Contents of the modelled RAM for reads
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // RAM model: random latency per access, address-derived read data, write scoreboard
  logic busy = 1'b0;
  int   lat = 0, rcnt = 0;
  always @(negedge CLK) begin
    if (ram_ren && ram_wen) begin
      errors++;
      $display("FAIL strobes_both ren=%0b wen=%0b required=not both", ram_ren, ram_wen);
    end
    if (ram_ren || ram_wen) begin
      strobe_cnt++;
      if (!busy) begin
        busy = 1'b1;
        rcnt = 0;
        lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
      end
      ram_ready = (rcnt == lat);
      ram_load  = ram_ready ? rom(ram_addr) : $urandom;
      if (ram_ready && ram_wen) begin
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h required=none", ram_addr, ram_store);
        end else begin
          check("ram_write", {ram_addr, ram_store}, wq.pop_front());
        end
      end
      rcnt++;
    end else begin
      busy      = 1'b0;
      ram_ready = 1'b0;
      ram_load  = $urandom;
    end
  end

  // Monitor: pop and compare on every completion seen by a requester
  always @(negedge CLK) begin
    if (nRST) begin
      if (iREN && !iwait) begin
        if (iq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_i_done iload=%0h required=no completion", iload);
        end else begin
          check("iload", iload, iq.pop_front());
        end
        i_done_cyc = cyc;
        i_done_n++;
      end
      if ((dREN || dWEN) && !dwait) begin
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_d_done dload=%0h required=no completion", dload);
        end else begin
          logic [32:0] e;
          e = dq.pop_front();
          if (e[32]) check("dload", dload, e[31:0]);
        end
        d_done_cyc = cyc;
        d_done_n++;
      end
    end
  end

  task automatic do_i(input logic [31:0] a, input bit scr);
    int n;
    iaddr = a;
    iq.push_back(rom(a));
    iREN = 1'b1;
    n = 0;
    while (1) begin
      @(negedge CLK);
      if (!iwait) break;
      n++;
      if (scr && n == 2) iaddr = $urandom;
      if (n > 200) begin
        errors++;
        $display("FAIL i_wait_bound waited=%0d required=completion", n);
        break;
      end
    end
    @(posedge CLK);
    #1;
    iREN = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] a, input bit wr, input logic [31:0] data,
                      input bit scr, input bit exp_to);
    int n;
    daddr  = a;
    dstore = data;
    if (wr) begin
      wq.push_back({a, data});
      dq.push_back({1'b0, 32'h0});
      dWEN = 1'b1;
      dREN = 1'($urandom_range(0, 1));
    end else begin
      dq.push_back({1'b1, exp_to ? BAD : rom(a)});
      dREN = 1'b1;
    end
    n = 0;
    while (1) begin
      @(negedge CLK);
      if (!dwait) break;
      n++;
      if (scr && n == 2) begin
        daddr  = $urandom;
        dstore = $urandom;
      end
      if (n > 200) begin
        errors++;
        $display("FAIL d_wait_bound waited=%0d required=completion", n);
        break;
      end
    end
    @(posedge CLK);
    #1;
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, ni;
    int i_issued;
    int d_issued;
    logic [31:0] ps_i, ps_d;

    // Reset values with requests asserted
    repeat (2) @(negedge CLK);
    iREN = 1'b1;
    dREN = 1'b1;
    #1;
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 1);
    check("rst_strobes", {ram_ren, ram_wen}, 0);
    check("rst_addr_store", {ram_addr, ram_store}, 0);
    check("rst_loads", {iload, dload}, 0);
    check("rst_err", err, 0);
    iREN = 1'b0;
    dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    tick(1);

    // Minimum-latency fetch
    force_lat = 0;
    n0 = cyc;
    fork
      do_i(32'h40, 1'b0);
      begin
        @(negedge CLK);
        @(negedge CLK);
        check("t1_ram_ren", ram_ren, 1);
        check("t1_ram_addr", ram_addr, 32'h40);
      end
    join
    check("t1_latency", i_done_cyc - n0, 2);
    tick(1);

    // Simultaneous fetch and write: write first, fetch after
    n0 = cyc;
`ifdef MEM_ARB_PERF_EN
    ps_i = perf_istall;
    ps_d = perf_dstall;
`else
    ps_i = 0;
    ps_d = 0;
`endif
    fork
      do_d(32'h80, 1'b1, 32'hCAFE, 1'b0, 1'b0);
      do_i(32'h104, 1'b0);
    join
    check("t2_d_latency", d_done_cyc - n0, 2);
    check("t2_i_latency", i_done_cyc - n0, 5);
`ifdef MEM_ARB_PERF_EN
    check("t2_perf_dstall", perf_dstall - ps_d, 2);
    check("t2_perf_istall", perf_istall - ps_i, 5);
`else
    if (ps_i != ps_d) $display("perf snapshot unused");
`endif
    tick(1);

    // Randomized rounds
    force_lat = -1;
    i_issued = i_done_n;
    d_issued = d_done_n;
    for (int r = 0; r < 60; r++) begin
      int kind;
      logic [31:0] ra, rb, rd;
      bit rw;
      kind = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      rd = $urandom;
      rw = 1'($urandom_range(0, 1));
      case (kind)
        0: begin do_i(ra, 1'b1); i_issued++; end
        1: begin do_d(ra, 1'b0, rd, 1'b1, 1'b0); d_issued++; end
        2: begin do_d(ra, 1'b1, rd, 1'b1, 1'b0); d_issued++; end
        default: begin
          fork
            do_d(ra, rw, rd, 1'b1, 1'b0);
            do_i(rb, 1'b0);
          join
          i_issued++;
          d_issued++;
          check("pair_d_before_i", (i_done_cyc > d_done_cyc), 1);
        end
      endcase
      tick($urandom_range(0, 2));
    end
    check("rand_i_count", i_done_n, i_issued);
    check("rand_d_count", d_done_n, d_issued);

    // Timeout on a data read
    tick(1);
    check("t3_err_before", err, 0);
    force_lat = 1000;
    strobe_cnt = 0;
    n0 = cyc;
    do_d(32'h220, 1'b0, 32'h0, 1'b0, 1'b1);
    check("t3_access_cycles", strobe_cnt, TO);
    check("t3_latency", d_done_cyc - n0, TO + 1);
    check("t3_err", err, 1);
    tick(1);

    // Fetch dropped mid-access
    ni = i_done_n;
    iaddr = 32'h200;
    iREN = 1'b1;
    tick(3);
    iREN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("t4_strobes_after_abort", {ram_ren, ram_wen}, 0);
    check("t4_no_completion", i_done_n, ni);
    @(posedge CLK);
    #1;
    force_lat = 0;
    n0 = cyc;
    do_i(32'h244, 1'b0);
    check("t4_fresh_latency", i_done_cyc - n0, 2);

    // Reset in the middle of a data access
    force_lat = 1000;
    daddr = 32'h300;
    dREN = 1'b1;
    tick(3);
    #2;
    nRST = 1'b0;
    #1;
    check("t5_strobes", {ram_ren, ram_wen}, 0);
    check("t5_addr_store", {ram_addr, ram_store}, 0);
    check("t5_loads", {iload, dload}, 0);
    check("t5_err_cleared", err, 0);
    check("t5_waits", {dwait, iwait}, 2'b10);
    dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    force_lat = 0;
    n0 = cyc;
    do_d(32'h304, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t5_fresh_latency", d_done_cyc - n0, 2);
    tick(2);

    check("drain_iq", iq.size(), 0);
    check("drain_dq", dq.size(), 0);
    check("drain_wq", wq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
